// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared types and constants for the shift-add multiplier
//                controller: state encoding, default sizes and the Moore
//                output decode used by mult_control.
//  Revision    : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Default operand width and iteration counter width (2**CNT_W > WIDTH).
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 6;

  // State encoding shared with anything that inspects the controller.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Outputs that depend on the state register only.
  typedef struct packed {
    logic b_sel;
    logic a_sel;
    logic prod_sel;
    logic busy;
    logic done;
  } ctrl_t;

  // Moore decode. LOAD selects the operand loads and clears the product;
  // every other state leaves the product register holding (add_sel is
  // handled separately because it also depends on the B LSB in RUN).
  function automatic ctrl_t ctrl_decode(input state_t s);
    ctrl_t c;
    c.b_sel    = 1'b1;
    c.a_sel    = 1'b1;
    c.prod_sel = 1'b1;
    c.busy     = 1'b0;
    c.done     = 1'b0;
    case (s)
      LOAD: begin
        c.b_sel    = 1'b0;
        c.a_sel    = 1'b0;
        c.prod_sel = 1'b0;
        c.busy     = 1'b1;
      end
      RUN:     c.busy = 1'b1;
      DONE:    c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_control_if
//  Description : Handshake and datapath-select bundle between the multiplier
//                controller (slave side) and its user/datapath (master side).
//  Revision    : 1.0  initial release
// ============================================================================
interface mult_control_if #(
  parameter int CNT_W = mult_pkg::DEFAULT_CNT_W
);

  // Handshake from the consumer and LSB feedback from the datapath.
  logic             Start;
  logic             Ack;
  logic             iB_LSB;

  // Datapath selects and status.
  logic             b_sel;
  logic             a_sel;
  logic             add_sel;
  logic             prod_sel;
  logic             Busy;
  logic             Done;
  logic [CNT_W-1:0] Iter;

  // Controller side.
  modport slave (
    input  Start,
    input  Ack,
    input  iB_LSB,
    output b_sel,
    output a_sel,
    output add_sel,
    output prod_sel,
    output Busy,
    output Done,
    output Iter
  );

  // Requester / datapath side.
  modport master (
    output Start,
    output Ack,
    output iB_LSB,
    input  b_sel,
    input  a_sel,
    input  add_sel,
    input  prod_sel,
    input  Busy,
    input  Done,
    input  Iter
  );

endinterface
`default_nettype wire

// File: rtl/mult_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mult_iter_counter
//  Description : Iteration counter for the shift-add sequence. Clears to 0,
//                increments on request and saturates at WIDTH-1, flagging
//                the terminal count.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tc;

  assign tc = (cnt_q == TC_VAL);

  // Next count: clear wins, otherwise step until the terminal value and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = tc;

endmodule
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// ============================================================================
//  Module      : mult_control
//  Description : Four-state controller for a WIDTH-iteration shift-add
//                multiplier. Drives the A/B/product selects of the datapath,
//                runs exactly WIDTH add/shift cycles per operation and holds
//                the result with Done high until the consumer acknowledges.
//  Revision    : 1.0  initial release
// ============================================================================
module mult_control
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic         Clock,
  input  logic         Reset,
  mult_control_if.slave bus
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] iter;
  logic             iter_tc;
  logic             iter_clr;
  logic             iter_inc;
  ctrl_t            ctrl;

  // State register; reset overrides any Start/Ack seen in the same cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Start is only looked at in IDLE and DONE, Ack only in
  // DONE, so requests arriving mid-operation are dropped rather than queued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = RUN;
      end
      RUN: begin
        if (iter_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.Ack) begin
          state_d = bus.Start ? LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // LOAD zeroes the counter so the first RUN cycle reports iteration 0;
  // the counter saturates at WIDTH-1 and that value stays visible in DONE.
  assign iter_clr = (state_q == LOAD);
  assign iter_inc = (state_q == RUN);

  mult_iter_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .Clock (Clock),
    .Reset (Reset),
    .clr_i (iter_clr),
    .inc_i (iter_inc),
    .cnt_o (iter),
    .tc_o  (iter_tc)
  );

  // Moore outputs decoded from the state register only.
  always_comb begin
    ctrl = ctrl_decode(state_q);
  end

  assign bus.b_sel    = ctrl.b_sel;
  assign bus.a_sel    = ctrl.a_sel;
  assign bus.prod_sel = ctrl.prod_sel;
  assign bus.Busy     = ctrl.busy;
  assign bus.Done     = ctrl.done;
  assign bus.Iter     = iter;

  // The add decision must follow the current B LSB in the same cycle, so it
  // is a direct AND with the RUN decode and carries no register.
  assign bus.add_sel  = (state_q == RUN) & bus.iB_LSB;

endmodule
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_control
//  Description : Self-checking bench for mult_control with a behavioural
//                shift-add datapath attached; products are compared against
//                plain multiplication and timing against the cycle budget.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mult_control;
  import mult_pkg::*;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  mult_control_if #(.CNT_W(CNT_W)) bus ();

  mult_control #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  // Behavioural datapath steered by the controller selects.
  logic [31:0] opA  = '0;
  logic [31:0] opB  = '0;
  logic [63:0] dp_a = '0;
  logic [31:0] dp_b = '0;
  logic [63:0] dp_p = '0;
  logic        force_en  = 1'b0;
  logic        force_val = 1'b0;

  always @(posedge Clock) begin
    dp_b <= bus.b_sel ? (dp_b >> 1) : opB;
    dp_a <= bus.a_sel ? (dp_a << 1) : {32'd0, opA};
    dp_p <= bus.prod_sel ? (bus.add_sel ? dp_p + dp_a : dp_p) : 64'd0;
  end

  assign bus.iB_LSB = force_en ? force_val : dp_b[0];

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int start_cyc = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
  endtask

  task automatic exp_idle(input string tag);
    check({tag, ".busy"},  64'(bus.Busy),     64'd0);
    check({tag, ".done"},  64'(bus.Done),     64'd0);
    check({tag, ".bsel"},  64'(bus.b_sel),    64'd1);
    check({tag, ".asel"},  64'(bus.a_sel),    64'd1);
    check({tag, ".psel"},  64'(bus.prod_sel), 64'd1);
    check({tag, ".addsel"},64'(bus.add_sel),  64'd0);
  endtask

  task automatic exp_load(input string tag);
    check({tag, ".busy"},  64'(bus.Busy),     64'd1);
    check({tag, ".done"},  64'(bus.Done),     64'd0);
    check({tag, ".bsel"},  64'(bus.b_sel),    64'd0);
    check({tag, ".asel"},  64'(bus.a_sel),    64'd0);
    check({tag, ".psel"},  64'(bus.prod_sel), 64'd0);
    check({tag, ".addsel"},64'(bus.add_sel),  64'd0);
  endtask

  task automatic exp_run(input int i);
    logic lsb;
    lsb = force_en ? force_val : dp_b[0];
    check("run.busy",   64'(bus.Busy),     64'd1);
    check("run.done",   64'(bus.Done),     64'd0);
    check("run.iter",   64'(bus.Iter),     64'(i));
    check("run.bsel",   64'(bus.b_sel),    64'd1);
    check("run.asel",   64'(bus.a_sel),    64'd1);
    check("run.psel",   64'(bus.prod_sel), 64'd1);
    check("run.addsel", 64'(bus.add_sel),  64'(lsb));
  endtask

  task automatic start_from_idle(input logic [31:0] a, input logic [31:0] b);
    opA = a;
    opB = b;
    bus.Start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.Start = 1'b0;
  endtask

  // Called in the LOAD cycle; runs to DONE and stays there hold+1 cycles.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int start_at, input int ack_at, input int hold,
                        input bit toggle, input bit chk_prod);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    force_en = toggle;
    exp_load("load");
    for (int i = 0; i < WIDTH; i++) begin
      tick();
      if (toggle) force_val = (i % 2 == 1);
      bus.Start = (i == start_at);
      bus.Ack   = (i == ack_at);
      #1;
      exp_run(i);
    end
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    tick();
    force_en = 1'b0;
    check("latency", 64'(cyc - start_cyc), 64'(WIDTH + 2));
    for (int h = 0; h <= hold; h++) begin
      check("done.done",   64'(bus.Done),    64'd1);
      check("done.busy",   64'(bus.Busy),    64'd0);
      check("done.iter",   64'(bus.Iter),    64'(WIDTH - 1));
      check("done.addsel", 64'(bus.add_sel), 64'd0);
      check("done.psel",   64'(bus.prod_sel),64'd1);
      if (chk_prod) check("done.prod", dp_p, prod);
      if (h < hold) tick();
    end
  endtask

  // Acknowledge in DONE, optionally launching the next operation at once.
  task automatic ack_op(input bit chain, input logic [31:0] na, input logic [31:0] nb);
    bus.Ack   = 1'b1;
    bus.Start = chain;
    opA = na;
    opB = nb;
    start_cyc = cyc;
    tick();
    bus.Ack   = 1'b0;
    bus.Start = 1'b0;
    check("ack.done", 64'(bus.Done), 64'd0);
    if (!chain) exp_idle("after_ack");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, na, nb;
    bit chain;
    bus.Start = 1'b1;
    bus.Ack   = 1'b1;
    Reset     = 1'b1;
    // Start and Ack asserted during reset must leave the controller idle.
    tick();
    tick();
    exp_idle("reset");
    check("reset.iter", 64'(bus.Iter), 64'd0);
    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Ack   = 1'b0;
    tick();
    exp_idle("post_reset");
    check("post_reset.iter", 64'(bus.Iter), 64'd0);

    // Ack while idle is ignored.
    bus.Ack = 1'b1;
    tick();
    bus.Ack = 1'b0;
    tick();
    exp_idle("ack_in_idle");

    // Directed products.
    start_from_idle(32'd3, 32'd5);
    run_op(32'd3, 32'd5, -1, -1, 0, 1'b0, 1'b1);
    ack_op(1'b0, 32'd0, 32'd0);

    // Start and Ack during RUN ignored, long DONE hold, then back-to-back.
    start_from_idle(32'h0000_FFFF, 32'd0);
    run_op(32'h0000_FFFF, 32'd0, 10, 5, 10, 1'b0, 1'b1);
    ack_op(1'b1, 32'd1, 32'h8000_0000);
    run_op(32'd1, 32'h8000_0000, -1, -1, 1, 1'b0, 1'b1);
    ack_op(1'b0, 32'd0, 32'd0);

    // add_sel follows a toggling LSB within the same cycle.
    start_from_idle(32'h1234_5678, 32'h9ABC_DEF0);
    run_op(32'h1234_5678, 32'h9ABC_DEF0, -1, -1, 0, 1'b1, 1'b0);
    ack_op(1'b0, 32'd0, 32'd0);

    // Reset in the middle of RUN, then Start in the first cycle after release.
    start_from_idle(32'd7, 32'd9);
    exp_load("rst_load");
    for (int i = 0; i <= 15; i++) begin
      tick();
      exp_run(i);
    end
    Reset = 1'b1;
    tick();
    exp_idle("midrun_reset");
    check("midrun_reset.iter", 64'(bus.Iter), 64'd0);
    Reset     = 1'b0;
    bus.Start = 1'b1;
    opA = 32'd7;
    opB = 32'd9;
    start_cyc = cyc;
    tick();
    bus.Start = 1'b0;
    run_op(32'd7, 32'd9, -1, -1, 0, 1'b0, 1'b1);
    ack_op(1'b0, 32'd0, 32'd0);

    // Randomised operands, DONE hold lengths and chaining.
    a = $urandom;
    b = $urandom;
    chain = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (!chain) start_from_idle(a, b);
      run_op(a, b, -1, -1, $urandom_range(0, 3), 1'b0, 1'b1);
      na = $urandom;
      nb = $urandom;
      chain = (n < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      ack_op(chain, na, nb);
      a = na;
      b = nb;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 Parameter WIDTH, default 32: operand width and number of shift-add iterations.
REQ-002 Parameter CNT_W, default 6: iteration counter width; SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 Clock  input  1  system clock; all state updates on rising edge.
REQ-004 Reset  input  1  reset Reset, synchronous, active-high; clock Clock.
REQ-005 Start  input  1  request a multiply; sampled in IDLE, and in DONE together with Ack.
REQ-006 Ack  input  1  consumer has taken the product; sampled only in DONE.
REQ-007 iB_LSB  input  1  current LSB of the multiplier datapath's B register.
REQ-008 b_sel  output  1  1 = B register takes B>>1, 0 = B register loads operand B.
REQ-009 a_sel  output  1  1 = A register takes A<<1, 0 = A register loads operand A.
REQ-010 add_sel  output  1  1 = product path takes Product+A, 0 = product path holds Product.
REQ-011 prod_sel  output  1  1 = product register takes add-path result, 0 = product register clears to 0.
REQ-012 Busy  output  1  high in LOAD and RUN.
REQ-013 Done  output  1  high in DONE; product on datapath output is final and stable.
REQ-014 Iter  output  CNT_W  current iteration index, for debug and bench checking.

Function
REQ-015 FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-016 IDLE: Start=1 -> LOAD; otherwise stay in IDLE.
REQ-017 LOAD: unconditional -> RUN; Iter cleared to 0.
REQ-018 RUN: Iter increments by 1 each cycle; when Iter==WIDTH-1 -> DONE and Iter holds WIDTH-1.
REQ-019 DONE: Ack=1 and Start=1 -> LOAD (back-to-back); Ack=1 and Start=0 -> IDLE; Ack=0 -> stay in DONE.
REQ-020 Start in LOAD or RUN SHALL be ignored; there is no queuing.
REQ-021 Ack outside DONE SHALL be ignored.
REQ-022 LOAD outputs: b_sel=0, a_sel=0, prod_sel=0, add_sel=0.
REQ-023 RUN outputs: b_sel=1, a_sel=1, prod_sel=1, add_sel=iB_LSB. add_sel is combinational from iB_LSB in the same cycle (Mealy); no register on this path.
REQ-024 IDLE and DONE outputs: b_sel=1, a_sel=1, prod_sel=1, add_sel=0, so the product register holds; A/B shifting in these states is don't-care.
REQ-025 All outputs except add_sel SHALL be decoded from the state register only (Moore), glitch-free relative to Clock.
REQ-026 Latency: Start sampled at edge k -> LOAD in cycle k+1 -> RUN in cycles k+2..k+1+WIDTH -> Done=1 from cycle k+2+WIDTH; Start-to-Done is WIDTH+2 cycles.
REQ-027 Done SHALL stay high until the edge at which Ack=1 is sampled, then fall in the next cycle.
REQ-028 Exactly WIDTH RUN cycles per operation, independent of operand values; no early exit on B==0.

Reset
REQ-029 Reset=1 at a rising edge SHALL force IDLE, Iter=0, Busy=0, Done=0 and IDLE output values, from any state including mid-RUN.
REQ-030 Start or Ack asserted in the same cycle as Reset SHALL be ignored.
REQ-031 After Reset is released, the first Start SHALL be accepted in the cycle following the release.

Structure
REQ-032 A shared package mult_pkg SHALL hold the state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3) and the default WIDTH.
REQ-033 One sub-module, mult_iter_counter, SHALL be used, with clear, increment and terminal-count flag (==WIDTH-1); the FSM and output decode stay in mult_control.
REQ-034 The block SHALL connect pin-for-pin to the multiplier datapath select inputs and its B-LSB output, with no glue logic.

Verification
REQ-035 Reset, then Start pulse at cycle 2 -> LOAD in cycle 3, Busy=1 for 33 cycles, Done=1 at cycle 36 (WIDTH=32), Iter sequence 0..31.
REQ-036 Integrated with the datapath, A=3, B=5 -> Prod=15 at Done; A=0xFFFF, B=0 -> Prod=0; A=1, B=0x80000000 -> Prod=0x80000000.
REQ-037 During RUN, toggle iB_LSB each cycle -> add_sel mirrors iB_LSB in the same cycle; other selects stay at 1.
REQ-038 Hold Ack=0 for 10 cycles in DONE -> Done stays 1 and product is unchanged; Ack=1 with Start=1 -> next cycle is LOAD and Done=0.
REQ-039 Start pulsed during RUN at Iter=10 -> ignored, Done timing unchanged; Reset at Iter=15 -> next cycle IDLE, Iter=0, Busy=0.
REQ-040 Ack asserted in IDLE and in RUN -> no state change; Start and Reset together -> remains in IDLE.
